// File: rtl/hash_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : hash_sequencer_if
//  Description : Host job handshake plus hash-core / memory control strobes
//                of the hash round sequencer, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hash_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int BLK_W  = 16
) ();

   // host job request
   logic              start;
   logic              abort;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] message_addr;
   logic [ADDR_W-1:0] output_addr;
   logic [BLK_W-1:0]  num_blocks;

   // memory, core control and status
   logic [ADDR_W-1:0] mem_ptr;
   logic              mem_rd;
   logic              mem_wr;
   logic [6:0]        round;
   logic [BLK_W-1:0]  chunk;
   logic              hash_en;
   logic              chunk_start;
   logic              chunk_done;
   logic              busy;
   logic              done;
   logic              err;

   // host side: issues jobs, watches the strobes
   modport master (
      output start, abort, mode, message_addr, output_addr, num_blocks,
      input  mem_ptr, mem_rd, mem_wr, round, chunk, hash_en,
             chunk_start, chunk_done, busy, done, err
   );

   // sequencer side
   modport slave (
      input  start, abort, mode, message_addr, output_addr, num_blocks,
      output mem_ptr, mem_rd, mem_wr, round, chunk, hash_en,
             chunk_start, chunk_done, busy, done, err
   );

endinterface
`default_nettype wire

// File: rtl/hash_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hash_sequencer
//  Description : Multi-mode (MD5 / SHA-1 / SHA-256) round sequencer. Walks a
//                multi-block message through the compression rounds, drives
//                the message word address and core strobes, then writes the
//                digest words back to memory. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_sequencer #(
   parameter int ADDR_W = 16,
   parameter int BLK_W  = 16,
   parameter int WPB    = 16
) (
   input  wire logic         clk,
   input  wire logic         reset_en,
   hash_sequencer_if.slave   bus
);

   localparam int c_WPB_LOG = $clog2(WPB);

   localparam logic [1:0] c_MODE_MD5  = 2'b00;
   localparam logic [1:0] c_MODE_SHA1 = 2'b01;
   localparam logic [1:0] c_MODE_S256 = 2'b10;
   localparam logic [1:0] c_MODE_RSVD = 2'b11;

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_LOAD    = 3'd1;
   localparam logic [2:0] c_COMPUTE = 3'd2;
   localparam logic [2:0] c_FINAL   = 3'd3;
   localparam logic [2:0] c_WRITE   = 3'd4;
   localparam logic [2:0] c_DONE    = 3'd5;

   // state and job registers
   logic [2:0]        r_state;
   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_msg_addr;
   logic [ADDR_W-1:0] r_out_addr;
   logic [BLK_W-1:0]  r_num_blocks;

   // registered outputs
   logic [ADDR_W-1:0] r_mem_ptr;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [6:0]        r_round;
   logic [BLK_W-1:0]  r_chunk;
   logic              r_hash_en;
   logic              r_chunk_start;
   logic              r_chunk_done;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   // next-state values
   logic [2:0]        w_state_nx;
   logic [6:0]        w_round_nx;
   logic [BLK_W-1:0]  w_chunk_nx;
   logic              w_enter_compute;
   logic              w_enter_write;
   logic              w_chunk_done_nx;
   logic              w_done_nx;
   logic              w_busy_nx;
   logic              w_err_nx;
   logic              w_latch;

   logic [6:0]        w_last_round;
   logic [6:0]        w_last_word;
   logic              w_more_blocks;
   logic              w_abortable;
   logic [3:0]        w_word_idx;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_blk_base;
   logic [ADDR_W-1:0] w_rd_ptr;
   logic [ADDR_W-1:0] w_wr_ptr;

   // Message word index within a block. Only the low four bits of the round
   // matter because every MD5 permutation is taken modulo 16.
   function automatic logic [3:0] f_word_index(input logic [3:0] i,
                                                input logic [1:0] quarter,
                                                input logic       md5);
      logic [3:0] g;
      g = i;
      if (md5) begin
         case (quarter)
            2'd0:    g = i;
            2'd1:    g = i * 4'd5 + 4'd1;
            2'd2:    g = i * 4'd3 + 4'd5;
            default: g = i * 4'd7;
         endcase
      end
      return g;
   endfunction

   // Per-mode last round and last digest word (reserved mode never computes).
   always_comb begin
      w_last_round = 7'd63;
      w_last_word  = 7'd3;
      case (r_mode)
         c_MODE_SHA1: begin w_last_round = 7'd79; w_last_word = 7'd4; end
         c_MODE_S256: begin w_last_round = 7'd63; w_last_word = 7'd7; end
         default:     begin w_last_round = 7'd63; w_last_word = 7'd3; end
      endcase
   end

   assign w_more_blocks = ((BLK_W+1)'(r_chunk) + (BLK_W+1)'(1)) < (BLK_W+1)'(r_num_blocks);
   assign w_abortable   = (r_state == c_LOAD) || (r_state == c_COMPUTE) ||
                          (r_state == c_FINAL) || (r_state == c_WRITE);

   // Next state, round/block counters and strobe intent; abort overrides all.
   always_comb begin
      w_state_nx      = r_state;
      w_round_nx      = r_round;
      w_chunk_nx      = r_chunk;
      w_enter_compute = 1'b0;
      w_enter_write   = 1'b0;
      w_chunk_done_nx = 1'b0;
      w_done_nx       = 1'b0;
      w_busy_nx       = 1'b1;
      w_err_nx        = r_err;
      w_latch         = 1'b0;
      case (r_state)
         c_IDLE: begin
            w_busy_nx = 1'b0;
            if (bus.start) begin
               w_state_nx = c_LOAD;
               w_busy_nx  = 1'b1;
               w_err_nx   = 1'b0;
               w_latch    = 1'b1;
               w_round_nx = 7'd0;
               w_chunk_nx = '0;
            end
         end
         c_LOAD: begin
            if (r_mode == c_MODE_RSVD) begin
               w_state_nx = c_DONE;
               w_done_nx  = 1'b1;
               w_err_nx   = 1'b1;
            end else if (r_num_blocks == '0) begin
               w_state_nx    = c_WRITE;
               w_round_nx    = 7'd0;
               w_enter_write = 1'b1;
            end else begin
               w_state_nx      = c_COMPUTE;
               w_round_nx      = 7'd0;
               w_chunk_nx      = '0;
               w_enter_compute = 1'b1;
            end
         end
         c_COMPUTE: begin
            if (r_round == w_last_round) begin
               w_state_nx      = c_FINAL;
               w_chunk_done_nx = 1'b1;
            end else begin
               w_round_nx      = r_round + 7'd1;
               w_enter_compute = 1'b1;
            end
         end
         c_FINAL: begin
            w_chunk_nx = r_chunk + BLK_W'(1);
            w_round_nx = 7'd0;
            if (w_more_blocks) begin
               w_state_nx      = c_COMPUTE;
               w_enter_compute = 1'b1;
            end else begin
               w_state_nx    = c_WRITE;
               w_enter_write = 1'b1;
            end
         end
         c_WRITE: begin
            if (r_round == w_last_word) begin
               w_state_nx = c_DONE;
               w_done_nx  = 1'b1;
            end else begin
               w_round_nx    = r_round + 7'd1;
               w_enter_write = 1'b1;
            end
         end
         c_DONE: begin
            w_state_nx = c_IDLE;
            w_busy_nx  = 1'b0;
         end
         default: begin
            w_state_nx = c_IDLE;
            w_busy_nx  = 1'b0;
         end
      endcase
      if (w_abortable && bus.abort) begin
         w_state_nx      = c_IDLE;
         w_round_nx      = r_round;
         w_chunk_nx      = r_chunk;
         w_enter_compute = 1'b0;
         w_enter_write   = 1'b0;
         w_chunk_done_nx = 1'b0;
         w_done_nx       = 1'b0;
         w_busy_nx       = 1'b0;
         w_err_nx        = r_err;
      end
   end

   // Address of the round being entered; SHA rounds past 15 read nothing.
   assign w_word_idx = f_word_index(w_round_nx[3:0], w_round_nx[5:4], r_mode == c_MODE_MD5);
   assign w_rd_en    = (r_mode == c_MODE_MD5) || (w_round_nx < 7'd16);
   assign w_blk_base = ADDR_W'(w_chunk_nx) << c_WPB_LOG;
   assign w_rd_ptr   = r_msg_addr + w_blk_base + ADDR_W'(w_word_idx);
   assign w_wr_ptr   = r_out_addr + ADDR_W'(w_round_nx);

   // Register state, job parameters and every output.
   always_ff @(posedge clk or negedge reset_en) begin
      if (!reset_en) begin
         r_state       <= c_IDLE;
         r_mode        <= 2'b00;
         r_msg_addr    <= '0;
         r_out_addr    <= '0;
         r_num_blocks  <= '0;
         r_mem_ptr     <= '0;
         r_mem_rd      <= 1'b0;
         r_mem_wr      <= 1'b0;
         r_round       <= 7'd0;
         r_chunk       <= '0;
         r_hash_en     <= 1'b0;
         r_chunk_start <= 1'b0;
         r_chunk_done  <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_round       <= w_round_nx;
         r_chunk       <= w_chunk_nx;
         r_hash_en     <= w_enter_compute;
         r_chunk_start <= w_enter_compute && (w_round_nx == 7'd0);
         r_mem_rd      <= w_enter_compute && w_rd_en;
         r_mem_wr      <= w_enter_write;
         r_chunk_done  <= w_chunk_done_nx;
         r_done        <= w_done_nx;
         r_busy        <= w_busy_nx;
         r_err         <= w_err_nx;
         if (w_enter_compute && w_rd_en) begin
            r_mem_ptr <= w_rd_ptr;
         end else if (w_enter_write) begin
            r_mem_ptr <= w_wr_ptr;
         end
         if (w_latch) begin
            r_mode       <= bus.mode;
            r_msg_addr   <= bus.message_addr;
            r_out_addr   <= bus.output_addr;
            r_num_blocks <= bus.num_blocks;
         end
      end
   end

   assign bus.mem_ptr     = r_mem_ptr;
   assign bus.mem_rd      = r_mem_rd;
   assign bus.mem_wr      = r_mem_wr;
   assign bus.round       = r_round;
   assign bus.chunk       = r_chunk;
   assign bus.hash_en     = r_hash_en;
   assign bus.chunk_start = r_chunk_start;
   assign bus.chunk_done  = r_chunk_done;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hash_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hash_sequencer
//  Description : Directed bench for hash_sequencer. Each job pushes its
//                expected memory / completion events into a queue; the events
//                seen on the bus are popped and compared as they occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_sequencer;

   logic clk = 1'b0;
   logic reset_en;

   hash_sequencer_if #(.ADDR_W(16), .BLK_W(16)) bus ();

   hash_sequencer #(.ADDR_W(16), .BLK_W(16), .WPB(16)) dut (
      .clk      (clk),
      .reset_en (reset_en),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [63:0] q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // {kind, ptr, round, hash_en, chunk_start, err, cycle}; kind 0 rd, 1 wr, 2 chunk_done, 3 done
   function automatic logic [63:0] pack(input logic [1:0] k, input logic [15:0] p,
                                        input logic [6:0] r, input logic he,
                                        input logic cs, input logic er, input int c);
      return {4'b0, k, p, r, he, cs, er, c};
   endfunction

   function automatic logic [63:0] all_outputs();
      return 64'({bus.mem_ptr, bus.mem_rd, bus.mem_wr, bus.round, bus.chunk,
                  bus.hash_en, bus.chunk_start, bus.chunk_done, bus.busy,
                  bus.done, bus.err});
   endfunction

   function automatic int md5_g(input int r);
      case (r / 16)
         0:       return r;
         1:       return (5 * r + 1) % 16;
         2:       return (3 * r + 5) % 16;
         default: return (7 * r) % 16;
      endcase
   endfunction

   // Expected event list for one job; events after cycle 'cut' are dropped.
   function automatic void build_expected(input logic [1:0] m, input logic [15:0] msg,
                                          input logic [15:0] out, input int n,
                                          input int rr, input int dd, input int cut);
      int base;
      if (m == 2'b11) begin
         q.push_back(pack(2'd3, 16'h0, 7'h0, 1'b0, 1'b0, 1'b1, 2));
         return;
      end
      for (int b = 0; b < n; b++) begin
         for (int r = 0; r < rr; r++) begin
            int cyc;
            int g;
            cyc = 2 + b * (rr + 1) + r;
            if ((m == 2'b00 || r < 16) && cyc <= cut) begin
               g = (m == 2'b00) ? md5_g(r) : r;
               q.push_back(pack(2'd0, 16'(int'(msg) + b * 16 + g), 7'(r),
                                1'b1, r == 0, 1'b0, cyc));
            end
         end
         if (2 + b * (rr + 1) + rr <= cut)
            q.push_back(pack(2'd2, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0, 2 + b * (rr + 1) + rr));
      end
      base = 2 + n * (rr + 1);
      for (int k = 0; k < dd; k++) begin
         if (base + k <= cut)
            q.push_back(pack(2'd1, 16'(int'(out) + k), 7'(k), 1'b0, 1'b0, 1'b0, base + k));
      end
      if (base + dd <= cut)
         q.push_back(pack(2'd3, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0, base + dd));
   endfunction

   // One job from the current negedge: start is sampled at the next edge,
   // the LOAD cycle is cycle 1. Optional abort and start-while-busy cycles.
   task automatic run_job(input logic [1:0] m, input logic [15:0] msg,
                          input logic [15:0] out, input logic [15:0] n,
                          input int abort_cyc, input int pulse_cyc);
      int rr, dd, cut, budget;
      bit expect_done, done_seen, ev;
      logic [1:0] kind;
      logic [63:0] obs;
      rr = (m == 2'b01) ? 80 : 64;
      dd = (m == 2'b01) ? 5 : (m == 2'b10) ? 8 : 4;
      expect_done = (abort_cyc == 0);
      cut = expect_done ? 32'h4000_0000 : abort_cyc;
      q.delete();
      build_expected(m, msg, out, int'(n), rr, dd, cut);
      if (!expect_done)     budget = abort_cyc + 40;
      else if (m == 2'b11)  budget = 12;
      else                  budget = 2 + int'(n) * (rr + 1) + dd + 10;
      bus.mode = m; bus.message_addr = msg; bus.output_addr = out;
      bus.num_blocks = n; bus.start = 1'b1; bus.abort = 1'b0;
      done_seen = 1'b0;
      for (int c = 1; c <= budget && !done_seen; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         if (c == 1) begin
            bus.mode         = ~m;
            bus.message_addr = msg ^ 16'h5A5A;
            bus.output_addr  = out ^ 16'hA5A5;
            bus.num_blocks   = n + 16'd3;
         end
         ev = 1'b1;
         kind = 2'd0;
         if (bus.mem_rd)          kind = 2'd0;
         else if (bus.mem_wr)     kind = 2'd1;
         else if (bus.chunk_done) kind = 2'd2;
         else if (bus.done)       kind = 2'd3;
         else                     ev = 1'b0;
         if (ev) begin
            obs = pack(kind, (kind < 2'd2) ? bus.mem_ptr : 16'h0,
                       (kind < 2'd2) ? bus.round : 7'h0,
                       bus.hash_en, bus.chunk_start, bus.err, c);
            if (q.size() == 0) check("unexpected_event", obs, '1);
            else               check("event", obs, q.pop_front());
            if (kind == 2'd3) done_seen = 1'b1;
         end
         if (abort_cyc != 0 && c == abort_cyc + 1)
            check("abort_idle", 64'({bus.busy, bus.mem_rd, bus.mem_wr, bus.hash_en,
                                     bus.chunk_start, bus.chunk_done, bus.done, bus.err}), 64'h0);
         if (c == abort_cyc) bus.abort = 1'b1;
         if (c == pulse_cyc) bus.start = 1'b1;
      end
      check("done_seen", 64'(done_seen), 64'(expect_done));
      check("events_left", 64'(q.size()), 64'h0);
      q.delete();
      @(negedge clk);
      bus.start = 1'b0;
      check("idle_after", 64'({bus.busy, bus.done, bus.mem_wr, bus.err}),
            64'({1'b0, 1'b0, 1'b0, (m == 2'b11) && expect_done}));
   endtask

   initial begin
      bit saw;
      reset_en = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'b00;
      bus.message_addr = 16'h0; bus.output_addr = 16'h0; bus.num_blocks = 16'h0;
      repeat (2) @(negedge clk);
      check("reset_state", all_outputs(), 64'h0);
      reset_en = 1'b1;
      @(negedge clk);

      // MD5, one block, with a start pulse while busy
      run_job(2'b00, 16'h0100, 16'h0200, 16'd1, 0, 20);
      // SHA-256, two blocks
      run_job(2'b10, 16'h1000, 16'h2000, 16'd2, 0, 0);
      // SHA-1, one block
      run_job(2'b01, 16'h3000, 16'h3100, 16'd1, 0, 0);
      // MD5 with no blocks: digest write only
      run_job(2'b00, 16'h4000, 16'h4100, 16'd0, 0, 0);
      // reserved mode
      run_job(2'b11, 16'h5000, 16'h5100, 16'd1, 0, 0);
      // back-to-back after the error job; err must clear
      run_job(2'b00, 16'h0100, 16'h0200, 16'd1, 0, 0);
      // abort during MD5 round 30
      run_job(2'b00, 16'h0100, 16'h0200, 16'd1, 32, 0);
      // address wrap on both read and write pointers
      run_job(2'b00, 16'hFFF8, 16'hFFFE, 16'd1, 0, 0);

      // asynchronous reset in the middle of WRITE
      bus.mode = 2'b00; bus.message_addr = 16'h0600; bus.output_addr = 16'h0700;
      bus.num_blocks = 16'd0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check("write_before_reset", 64'({bus.mem_wr, bus.mem_ptr}), 64'({1'b1, 16'h0701}));
      #2 reset_en = 1'b0;
      #1 check("async_reset", all_outputs(), 64'h0);
      @(negedge clk);
      reset_en = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done || bus.mem_wr || bus.busy) saw = 1'b1;
      end
      check("no_resume_after_reset", 64'(saw), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
